// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - decode/issue stage with busy scoreboard, RAW/WAW stall, writeback bypass
module issue_scoreboard #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  output logic [4:0]             read_reg1,
  output logic [4:0]             read_reg2,
  input  logic [XLEN-1:0]        reg1_value,
  input  logic [XLEN-1:0]        reg2_value,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_reg,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   flush,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [31:0]            issue_instr,
  output logic [XLEN-1:0]        issue_pc,
  output logic [XLEN-1:0]        issue_op1,
  output logic [XLEN-1:0]        issue_op2,
  output logic [4:0]             issue_rd,
  output logic                   issue_illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [31:0]            busy_q, busy_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [31:0]            issue_instr_q;
  logic [XLEN-1:0]        issue_pc_q, issue_op1_q, issue_op2_q;
  logic [4:0]             issue_rd_q;
  logic                   issue_illegal_q;
  logic [STALL_CNT_W-1:0] stall_count_q;

  logic [4:0]      rs1, rs2, rd;
  logic [6:0]      opcode;
  logic            use_rs1, use_rs2, use_rd, illegal;
  logic            rd_wr;
  logic [31:0]     wb_mask, eff_busy;
  logic            hazard, accept;
  logic [XLEN-1:0] op1, op2;

  assign opcode    = in_instr[6:0];
  assign rs1       = in_instr[19:15];
  assign rs2       = in_instr[24:20];
  assign rd        = in_instr[11:7];
  assign read_reg1 = rs1;
  assign read_reg2 = rs2;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    unique case (opcode)
      7'b0110011:                         begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin use_rs1 = 1'b1; use_rd = 1'b1; end
      7'b0100011, 7'b1100011:             begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b1101111, 7'b0110111, 7'b0010111: use_rd = 1'b1;
      default:                            illegal = 1'b1;
    endcase
  end

  // x0 is never marked busy, so a zero source or destination can never raise a hazard.
  assign rd_wr    = use_rd && (rd != 5'd0);
  assign wb_mask  = wb_valid ? (32'd1 << wb_reg) : 32'd0;
  assign eff_busy = busy_q & ~wb_mask;
  assign hazard   = in_valid && ((use_rs1 && eff_busy[rs1]) ||
                                 (use_rs2 && eff_busy[rs2]) ||
                                 (use_rd  && eff_busy[rd]));
  assign in_ready = !hazard && (!issue_valid_q || issue_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (use_rs1) op1 = (wb_valid && wb_reg == rs1 && rs1 != 5'd0) ? wb_data : reg1_value;
    if (use_rs2) op2 = (wb_valid && wb_reg == rs2 && rs2 != 5'd0) ? wb_data : reg2_value;
  end

  // Writeback clear first, then the new destination set, so a same-register collision stays busy.
  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (accept && rd_wr) busy_d = busy_d | (32'd1 << rd);
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    if (flush)            issue_valid_d = 1'b0;
    else if (accept)      issue_valid_d = 1'b1;
    else if (issue_ready) issue_valid_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q          <= '0;
      issue_valid_q   <= 1'b0;
      issue_instr_q   <= '0;
      issue_pc_q      <= '0;
      issue_op1_q     <= '0;
      issue_op2_q     <= '0;
      issue_rd_q      <= '0;
      issue_illegal_q <= 1'b0;
      stall_count_q   <= '0;
    end else begin
      busy_q        <= busy_d;
      issue_valid_q <= issue_valid_d;
      if (accept) begin
        issue_instr_q   <= in_instr;
        issue_pc_q      <= in_pc;
        issue_op1_q     <= op1;
        issue_op2_q     <= op2;
        issue_rd_q      <= rd_wr ? rd : 5'd0;
        issue_illegal_q <= illegal;
      end
      if (hazard && !flush && !(&stall_count_q))
        stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign issue_valid   = issue_valid_q;
  assign issue_instr   = issue_instr_q;
  assign issue_pc      = issue_pc_q;
  assign issue_op1     = issue_op1_q;
  assign issue_op2     = issue_op2_q;
  assign issue_rd      = issue_rd_q;
  assign issue_illegal = issue_illegal_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed self-checking bench for issue_scoreboard
module tb_issue_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] reg1_value, reg2_value;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_instr, issue_pc, issue_op1, issue_op2;
  logic [4:0]  issue_rd;
  logic        issue_illegal;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  issue_scoreboard #(.XLEN(32), .STALL_CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .reg1_value(reg1_value), .reg2_value(reg2_value),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_pc(issue_pc),
    .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_rd(issue_rd), .issue_illegal(issue_illegal),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
  localparam logic [31:0] ADD_X2  = 32'h0010_8133;
  localparam logic [31:0] LUI_X3  = 32'h0000_01B7;
  localparam logic [31:0] ADDI_X5 = 32'h0010_0293;
  localparam logic [31:0] ADD_X6  = 32'h0001_0333;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    reg1_value = '0; reg2_value = '0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    flush = 1'b0; issue_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_valid", issue_valid, 0);
    check("rst_stall", stall_count, 0);
    check("rst_busy", dut.busy_q, 0);
    check("rst_instr", issue_instr, 0);

    // addi x1,x0,5
    in_valid = 1'b1; in_instr = ADDI_X1; in_pc = 32'h100;
    #1;
    check("addi_ready", in_ready, 1);
    check("addi_rr1", read_reg1, 0);
    check("addi_rr2", read_reg2, 5);
    step();
    check("addi_valid", issue_valid, 1);
    check("addi_rd", issue_rd, 1);
    check("addi_pc", issue_pc, 32'h100);
    check("addi_op1", issue_op1, 0);
    check("addi_busy", dut.busy_q, 32'h2);

    // add x2,x1,x1 stalls on x1
    in_instr = ADD_X2; in_pc = 32'h104; reg1_value = 32'h77; reg2_value = 32'h77;
    #1;
    check("raw_ready", in_ready, 0);
    check("raw_rr1", read_reg1, 1);
    step();
    check("raw_stall1", stall_count, 1);
    check("raw_drain", issue_valid, 0);
    step();
    check("raw_stall2", stall_count, 2);
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'd5;
    #1;
    check("byp_ready", in_ready, 1);
    step();
    wb_valid = 1'b0;
    check("byp_valid", issue_valid, 1);
    check("byp_op1", issue_op1, 5);
    check("byp_op2", issue_op2, 5);
    check("byp_rd", issue_rd, 2);
    check("byp_busy", dut.busy_q, 32'h4);
    check("byp_stall", stall_count, 2);

    // backpressure with a hazard-free lui x3 waiting
    issue_ready = 1'b0; in_instr = LUI_X3; in_pc = 32'h108;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", in_ready, 0);
      step();
      check("bp_valid", issue_valid, 1);
      check("bp_instr", issue_instr, ADD_X2);
      check("bp_pc", issue_pc, 32'h104);
    end
    issue_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    step();
    check("lui_instr", issue_instr, LUI_X3);
    check("lui_rd", issue_rd, 3);
    check("lui_op1", issue_op1, 0);
    check("lui_busy", dut.busy_q, 32'hC);

    // re-issue writer of x3 while x3 writes back: set wins
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h55; in_pc = 32'h10C;
    #1;
    check("sw_ready", in_ready, 1);
    step();
    wb_valid = 1'b0;
    check("sw_busy", dut.busy_q, 32'hC);
    check("sw_pc", issue_pc, 32'h10C);

    // flush while holding and presenting
    in_instr = ADDI_X5; in_pc = 32'h110; flush = 1'b1;
    #1;
    check("fl_ready", in_ready, 0);
    step();
    flush = 1'b0;
    check("fl_valid", issue_valid, 0);
    check("fl_busy", dut.busy_q, 32'hC);
    check("fl_pc", issue_pc, 32'h10C);

    // illegal opcode
    in_instr = 32'hFFFF_FFFF; in_pc = 32'h200; reg1_value = 32'h1234; reg2_value = 32'h5678;
    #1;
    check("ill_ready", in_ready, 1);
    step();
    check("ill_flag", issue_illegal, 1);
    check("ill_rd", issue_rd, 0);
    check("ill_op1", issue_op1, 0);
    check("ill_op2", issue_op2, 0);
    check("ill_busy", dut.busy_q, 32'hC);

    // add x6,x2,x0 stalls on x2 until the counter saturates
    in_instr = ADD_X6; in_pc = 32'h204;
    #1;
    check("sat_ready", in_ready, 0);
    step();
    check("sat_first", stall_count, 3);
    for (int i = 0; i < 65532; i++) step();
    check("sat_max", stall_count, 16'hFFFF);
    step(); step();
    check("sat_hold", stall_count, 16'hFFFF);
    check("sat_valid", issue_valid, 0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
